// File: rtl/bot_if_pkg.sv
// rtl/bot_if_pkg.sv - port map and per-bot register indices shared by the BOT interface
package bot_if_pkg;

  localparam logic [3:0] P_MOTCTL     = 4'h0;
  localparam logic [3:0] P_LOCX       = 4'h1;
  localparam logic [3:0] P_LOCY       = 4'h2;
  localparam logic [3:0] P_BOTINFO    = 4'h3;
  localparam logic [3:0] P_SENSORS    = 4'h4;
  localparam logic [3:0] P_CONFIG     = 4'h7;
  localparam logic [3:0] P_MAPX       = 4'h8;
  localparam logic [3:0] P_MAPY       = 4'h9;
  localparam logic [3:0] P_MAPVAL     = 4'hA;
  localparam logic [3:0] P_BOTSEL     = 4'hB;
  localparam logic [3:0] P_COMMIT     = 4'hC;
  localparam logic [3:0] P_STATUS     = 4'hD;
  localparam logic [3:0] P_UPDATE     = 4'hE;
  localparam logic [3:0] P_COMMIT_ALL = 4'hF;

  localparam int NUM_REGS = 4;

  typedef enum logic [1:0] {
    R_LOCX    = 2'd0,
    R_LOCY    = 2'd1,
    R_BOTINFO = 2'd2,
    R_SENSORS = 2'd3
  } bot_reg_e;

  // Ports 0x1..0x4 map onto register indices 0..3.
  function automatic bot_reg_e port_to_reg(input logic [3:0] port);
    return bot_reg_e'(port[1:0] - 2'd1);
  endfunction

endpackage

// File: rtl/bot_chan_regs.sv
// rtl/bot_chan_regs.sv - one bot's holding/visible registers, orientation tap and pending flag
module bot_chan_regs
  import bot_if_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hold_we,
  input  bot_reg_e      hold_idx,
  input  logic [DW-1:0] wdata,
  input  logic          commit,
  input  logic [2:0]    orient,
  input  logic          set_pend,
  input  logic          ack,
  output logic [DW-1:0] hold_locx,
  output logic [DW-1:0] hold_locy,
  output logic [DW-1:0] hold_info,
  output logic [DW-1:0] hold_sens,
  output logic [DW-1:0] vis_locx,
  output logic [DW-1:0] vis_locy,
  output logic [DW-1:0] vis_info,
  output logic [DW-1:0] vis_sens,
  output logic          pending
);

  logic [DW-1:0] hold_q [NUM_REGS];
  logic [DW-1:0] hold_d [NUM_REGS];
  logic [DW-1:0] vis_q  [NUM_REGS];
  logic [DW-1:0] vis_d  [NUM_REGS];
  logic [2:0]    orient_q;
  logic          pend_q, pend_d;

  // Commit copies the pre-edge holding values, so a same-cycle write is not committed.
  always_comb begin
    hold_d = hold_q;
    vis_d  = vis_q;
    if (hold_we) hold_d[hold_idx] = wdata;
    if (commit)  vis_d = hold_q;
    pend_d = set_pend | (pend_q & ~ack);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q   <= '{default: '0};
      vis_q    <= '{default: '0};
      orient_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      vis_q    <= vis_d;
      orient_q <= orient;
      pend_q   <= pend_d;
    end
  end

  assign hold_locx = hold_q[R_LOCX];
  assign hold_locy = hold_q[R_LOCY];
  assign hold_info = {hold_q[R_BOTINFO][DW-1:3], orient_q};
  assign hold_sens = hold_q[R_SENSORS];
  assign vis_locx  = vis_q[R_LOCX];
  assign vis_locy  = vis_q[R_LOCY];
  assign vis_info  = {vis_q[R_BOTINFO][DW-1:3], orient_q};
  assign vis_sens  = vis_q[R_SENSORS];
  assign pending   = pend_q;

endmodule

// File: rtl/bot_multi_if.sv
// rtl/bot_multi_if.sv - CPU-port register interface to NUM_BOTS bot channels with heartbeat watchdog
module bot_multi_if
  import bot_if_pkg::*;
#(
  parameter int NUM_BOTS    = 4,
  parameter int DW          = 8,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_strobe,
  input  logic                   rd_strobe,
  input  logic [7:0]             addr_in,
  input  logic [DW-1:0]          data_in,
  output logic [DW-1:0]          data_out,
  input  logic [NUM_BOTS*DW-1:0] mot_ctl,
  input  logic [NUM_BOTS*DW-1:0] bot_config,
  input  logic [NUM_BOTS*3-1:0]  new_orientation,
  output logic [NUM_BOTS*DW-1:0] loc_x,
  output logic [NUM_BOTS*DW-1:0] loc_y,
  output logic [NUM_BOTS*DW-1:0] bot_info,
  output logic [NUM_BOTS*DW-1:0] sensors,
  output logic [DW-1:0]          map_x,
  output logic [DW-1:0]          map_y,
  input  logic [1:0]             map_val,
  output logic [NUM_BOTS-1:0]    upd_pending,
  input  logic [NUM_BOTS-1:0]    upd_ack,
  output logic                   upd_irq,
  output logic                   wdog_stale
);

  localparam int SELW = (NUM_BOTS > 1) ? $clog2(NUM_BOTS) : 1;
  localparam int CNTW = $clog2(WDOG_CYCLES + 1);

  logic [3:0]      port;
  logic            hold_wr, commit_one, commit_all, upd_wr;
  logic [SELW-1:0] bot_sel_q, bot_sel_d;
  logic [DW-1:0]   map_x_q, map_x_d, map_y_q, map_y_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   h_locx [NUM_BOTS];
  logic [DW-1:0]   h_locy [NUM_BOTS];
  logic [DW-1:0]   h_info [NUM_BOTS];
  logic [DW-1:0]   h_sens [NUM_BOTS];
  logic            unused_ok;

  // Reads are unconditional and only the low nibble is decoded.
  assign unused_ok = ^{rd_strobe, addr_in[7:4]};

  assign port       = addr_in[3:0];
  assign hold_wr    = wr_strobe && (port >= P_LOCX) && (port <= P_SENSORS);
  assign commit_one = wr_strobe && (port == P_COMMIT);
  assign commit_all = wr_strobe && (port == P_COMMIT_ALL);
  assign upd_wr     = wr_strobe && (port == P_UPDATE);

  for (genvar k = 0; k < NUM_BOTS; k++) begin : g_bot
    logic sel_k;
    assign sel_k = (bot_sel_q == SELW'(k));

    bot_chan_regs #(.DW(DW)) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .hold_we   (hold_wr && sel_k),
      .hold_idx  (port_to_reg(port)),
      .wdata     (data_in),
      .commit    (commit_all || (commit_one && sel_k)),
      .orient    (new_orientation[k*3 +: 3]),
      .set_pend  (upd_wr && sel_k),
      .ack       (upd_ack[k]),
      .hold_locx (h_locx[k]),
      .hold_locy (h_locy[k]),
      .hold_info (h_info[k]),
      .hold_sens (h_sens[k]),
      .vis_locx  (loc_x[k*DW +: DW]),
      .vis_locy  (loc_y[k*DW +: DW]),
      .vis_info  (bot_info[k*DW +: DW]),
      .vis_sens  (sensors[k*DW +: DW]),
      .pending   (upd_pending[k])
    );
  end

  assign wdog_stale = (cnt_q == CNTW'(WDOG_CYCLES));

  always_comb begin
    bot_sel_d = bot_sel_q;
    map_x_d   = map_x_q;
    map_y_d   = map_y_q;
    if (wr_strobe) begin
      case (port)
        P_MAPX:   map_x_d = data_in;
        P_MAPY:   map_y_d = data_in;
        P_BOTSEL: if (data_in < DW'(NUM_BOTS)) bot_sel_d = data_in[SELW-1:0];
        default:  ;
      endcase
    end
    if (upd_wr)          cnt_d = '0;
    else if (wdog_stale) cnt_d = cnt_q;
    else                 cnt_d = cnt_q + CNTW'(1);
  end

  always_comb begin
    dout_d = '0;
    case (port)
      P_MOTCTL:  dout_d = mot_ctl[int'(bot_sel_q)*DW +: DW];
      P_LOCX:    dout_d = h_locx[bot_sel_q];
      P_LOCY:    dout_d = h_locy[bot_sel_q];
      P_BOTINFO: dout_d = h_info[bot_sel_q];
      P_SENSORS: dout_d = h_sens[bot_sel_q];
      P_CONFIG:  dout_d = bot_config[int'(bot_sel_q)*DW +: DW];
      P_MAPVAL:  dout_d = DW'(map_val);
      P_BOTSEL:  dout_d = DW'(bot_sel_q);
      P_STATUS:  dout_d = DW'({wdog_stale, upd_pending});
      default:   dout_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bot_sel_q <= '0;
      map_x_q   <= '0;
      map_y_q   <= '0;
      dout_q    <= '0;
      cnt_q     <= '0;
    end else begin
      bot_sel_q <= bot_sel_d;
      map_x_q   <= map_x_d;
      map_y_q   <= map_y_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign data_out = dout_q;
  assign map_x    = map_x_q;
  assign map_y    = map_y_q;
  assign upd_irq  = |upd_pending;

endmodule

// File: doc/bot_multi_if.md
BOT_MULTI_IF -- requirements
Module: bot_multi_if

Interface
REQ-001 Parameter NUM_BOTS, default 4, number of BOT channels (legal range 1..8).
REQ-002 Parameter DW, default 8, data width of the CPU port and of every BOT register.
REQ-003 Parameter WDOG_CYCLES, default 1000000, heartbeat timeout in clk cycles.
REQ-004 clk  in  1  system clock; all logic is rising-edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 wr_strobe, rd_strobe  in  1 each  CPU I/O write and read strobes.
REQ-007 addr_in  in  8  CPU port address; only bits [3:0] are decoded.
REQ-008 data_in  in  DW  CPU write data.
REQ-009 data_out  out  DW  CPU read data, registered.
REQ-010 mot_ctl, bot_config  in  NUM_BOTS*DW each  per-bot motor control and config words; bot k occupies slice [k*DW +: DW].
REQ-011 new_orientation  in  NUM_BOTS*3  per-bot orientation override.
REQ-012 loc_x, loc_y, bot_info, sensors  out  NUM_BOTS*DW each  user-visible per-bot state.
REQ-013 map_x, map_y  out  DW each  world-map column and row address.
REQ-014 map_val  in  2  world-map value.
REQ-015 upd_pending  out  NUM_BOTS  per-bot update-pending flags.
REQ-016 upd_ack  in  NUM_BOTS  per-bot acknowledge, single-cycle pulse.
REQ-017 upd_irq  out  1  OR of upd_pending.
REQ-018 wdog_stale  out  1  heartbeat timeout flag.

Function
REQ-019 Register bot_sel (port 0xB) SHALL select the channel for ports 0x0-0x7 and 0xC/0xE; a write with value >= NUM_BOTS SHALL be ignored.
REQ-020 A write to 0x1/0x2/0x3/0x4 SHALL update the selected bot's holding LocX/LocY/BotInfo/Sensors register; 0x8/0x9 SHALL update map_x/map_y; all other write addresses have no effect.
REQ-021 A read SHALL return on data_out one cycle after addr_in is presented, with the following mapping:
  - 0x0: mot_ctl[sel]
  - 0x1-0x4: holding registers
  - 0x7: bot_config[sel]
  - 0xA: zero-extended map_val
  - 0xB: zero-extended bot_sel
  - 0xD: {wdog_stale, upd_pending zero-extended}
  - others: 0
  data_out is updated every cycle regardless of rd_strobe.
REQ-022 A write to 0xC SHALL copy the selected bot's four holding registers to its visible outputs on the next clk edge; other bots' outputs are unchanged. This is a pulse command, not a toggle.
REQ-023 A write to 0xF SHALL commit all bots' holding registers simultaneously.
REQ-024 Bits [2:0] of every bot_info slice and of the holding BotInfo read value SHALL track new_orientation continuously with 1-cycle latency; bits [DW-1:3] come from the committed value.
REQ-025 A write to 0xE SHALL set upd_pending[sel] and restart the heartbeat counter.
REQ-026 upd_ack[k] SHALL clear upd_pending[k] on the next edge; if set and ack coincide on the same bit, set wins.
REQ-027 The heartbeat counter SHALL increment each cycle and saturate at WDOG_CYCLES. wdog_stale SHALL be 1 while the counter equals WDOG_CYCLES and SHALL clear the cycle after a 0xE write.
REQ-028 A commit (0xC/0xF) in the same cycle as a holding-register write SHALL commit the pre-write holding value.
REQ-029 Fields narrower than DW (map_val, bot_sel, pending vector) SHALL be zero-extended on read.

Reset
REQ-030 While reset_n=0 at a clk edge, the following SHALL be 0: all holding and visible registers, map_x, map_y, bot_sel, upd_pending, data_out, and the heartbeat counter. wdog_stale SHALL also be 0.
REQ-031 Reset asserted mid-operation SHALL abort a pending commit; no partial commit is visible after reset.

Structure
REQ-032 Port address constants (P_MOTCTL..P_COMMIT_ALL) and BOT register index constants SHALL live in shared package bot_if_pkg.
REQ-033 One sub-module, bot_chan_regs, SHALL be instantiated NUM_BOTS times (generate loop). It holds one bot's holding and visible registers plus its pending flag.

Verification
REQ-034 Reset: assert reset_n=0 for 2 cycles -> all outputs 0, wdog_stale=0.
REQ-035 Select bot 2, write 0x1=0x35, 0x2=0x12, then write 0xC -> loc_x[2]=0x35 and loc_y[2]=0x12 one cycle later; bots 0, 1 and 3 unchanged.
REQ-036 Write bot_sel=5 with NUM_BOTS=4 -> read 0xB returns the previous value.
REQ-037 Write 0xE with sel=1 -> upd_pending=4'b0010 and upd_irq=1. Pulse upd_ack[1] in the same cycle as another 0xE write -> upd_pending[1] stays 1.
REQ-038 WDOG_CYCLES=16 with no 0xE writes -> wdog_stale=1 at cycle 16; a 0xE write clears it next cycle.
REQ-039 Commit and holding write to 0x3 in the same cycle, with new_orientation[0]=3'b101 -> bot_info[0] holds the old bits [7:3] and bits [2:0]=3'b101.
